// File: rtl/mimo_pkg.sv
// Shared types and defaults for the 4x4 MIMO channel transmit model (y = H*s).
package mimo_pkg;

    localparam int N_ANT  = 4;
    localparam int DATA_W = 32;

    localparam int          FRAC_BITS_DEF   = 16;
    localparam int          NOISE_SHIFT_DEF = 20;
    localparam logic [15:0] LFSR_SEED_DEF   = 16'hACE1;

    typedef logic signed [DATA_W-1:0] fixed_t;
    typedef fixed_t vec_t [0:N_ANT-1];
    typedef fixed_t mat_t [0:N_ANT-1][0:N_ANT-1];

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/mimo_channel_tx_fixed_dot4.sv
// Combinational 4-term signed fixed-point dot product; each product is truncated
// toward -inf to the operand format, and the sum wraps modulo 2^DATA_W.
module fixed_dot4
    import mimo_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
)(
    input  vec_t   a_row,
    input  vec_t   b_vec,
    output fixed_t dot
);

    always_comb begin
        logic signed [2*DATA_W-1:0] a_w;
        logic signed [2*DATA_W-1:0] b_w;
        logic signed [2*DATA_W-1:0] prod;
        // NOTE: every variable written here gets a value before any branch or loop, so no latch can be inferred.
        dot  = '0;
        a_w  = '0;
        b_w  = '0;
        prod = '0;
        for (int j = 0; j < N_ANT; j++) begin
            a_w  = a_row[j];
            b_w  = b_vec[j];
            prod = a_w * b_w;
            dot  = dot + fixed_t'(prod >>> FRAC_BITS);
        end
    end

endmodule

// File: rtl/mimo_channel_tx.sv
// Time-multiplexed y = H*s generator, one row per cycle, valid/ready on both sides.
// Optional LFSR noise injection is enabled by defining NOISE_INJECT_EN.
module mimo_channel_tx
    import mimo_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
`ifdef NOISE_INJECT_EN
   ,parameter int          NOISE_SHIFT = NOISE_SHIFT_DEF,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
`endif
)(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  mat_t H_matrix,
    input  vec_t symbol_tx,
    output logic out_valid,
    input  logic out_ready,
    output vec_t signal_out
);

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic       out_valid_q, out_valid_d;
    mat_t       h_q, h_d;
    vec_t       s_q, s_d;
    vec_t       y_q, y_d;
    vec_t       cur_row;
    fixed_t     row_dot;
    fixed_t     row_term;

`ifdef NOISE_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;
    fixed_t      noise;

    assign noise    = fixed_t'($signed(lfsr_q)) >>> (NOISE_SHIFT - 16);
    assign row_term = row_dot + noise;
`else
    assign row_term = row_dot;
`endif

    always_comb begin
        for (int j = 0; j < N_ANT; j++) begin
            cur_row[j] = h_q[row_q][j];
        end
    end

    fixed_dot4 #(.FRAC_BITS(FRAC_BITS)) u_dot (
        .a_row (cur_row),
        .b_vec (s_q),
        .dot   (row_dot)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        h_d         = h_q;
        s_d         = s_q;
        y_d         = y_q;
        in_ready    = 1'b0;
`ifdef NOISE_INJECT_EN
        lfsr_d      = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    h_d     = H_matrix;
                    s_d     = symbol_tx;
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                y_d[row_q] = row_term;
                row_d      = row_q + 2'd1;
`ifdef NOISE_INJECT_EN
                lfsr_d     = lfsr_next(lfsr_q);
`endif
                if (row_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '{default: '0};
`ifdef NOISE_INJECT_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
`ifdef NOISE_INJECT_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // NOTE: the latched operand copies are not reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        h_q <= h_d;
        s_q <= s_d;
    end

    assign out_valid  = out_valid_q;
    assign signal_out = y_q;

endmodule
